exe_result_buffer_w15: RTL and testbench
========================================

// Module: exe_result_buffer_w15
// PURPOSE
//  Result buffer stage directly downstream of exe_unit_w15. Captures result/status pairs
//  from the execution unit under a valid/ready handshake and holds them in a small FIFO.
//  Presents them to the writeback/consumer side and keeps a saturating count of
//  erroneous results (status != 0) plus a sticky error flag.
// PARAMETERS
//  ARG_BYTES  4  bit width of result data; must match exe_unit_w15 ARG_BYTES
//  DEPTH      4  FIFO entries; power of two, >= 2
//  CNT_W      8  width of error counter
// PORTS
//  i_clk       in   1              clock, all state on rising edge
//  i_rsn       in   1              reset, asynchronous, active-low
//  i_valid     in   1              upstream result valid
//  i_result    in   ARG_BYTES      upstream result (exe_unit o_result)
//  i_status    in   3              upstream status (exe_unit o_status)
//  o_ready     out  1              buffer can accept an entry this cycle
//  o_valid     out  1              head entry available to consumer
//  o_result    out  ARG_BYTES      head entry result
//  o_status    out  3              head entry status
//  i_ready     in   1              consumer accepts head entry
//  i_clr       in   1              synchronous clear of error counter and sticky flag
//  o_count     out  $clog2(DEPTH)+1  current number of stored entries
//  o_err_cnt   out  CNT_W          saturating count of accepted entries with status != 0
//  o_err_seen  out  1              sticky: at least one erroneous entry since reset/clear
// BEHAVIOUR
//  - Reset (i_rsn low, async): rd/wr pointers=0, o_count=0, o_valid=0, o_result=0,
//    o_status=0, o_err_cnt=0, o_err_seen=0. Storage contents are don't-care.
//    Reset mid-operation discards all entries. i_valid is ignored while i_rsn is low.
//  - Push = i_valid & o_ready. Pop = o_valid & i_ready. Both evaluated at the same edge.
//  - o_ready = (o_count != DEPTH), combinational from registered count, no dependence on i_ready.
//  - o_valid = (o_count != 0). o_result/o_status show the head entry, or 0 when empty.
//  - Latency: an entry pushed at edge N is visible on o_valid/o_result after edge N (1 cycle).
//    There is no same-cycle pass-through when empty.
//  - Count update: push only +1; pop only -1; push & pop together: count unchanged, and the
//    head advances while the new entry is written at the tail.
//  - Full (count==DEPTH): o_ready=0. A pop in that cycle frees a slot for the next cycle only.
//  - Empty: pop impossible, since o_valid=0. i_ready is don't-care.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH without a bubble.
//  - Error count: on push with i_status != 3'b000, o_err_cnt += 1, saturating at 2^CNT_W-1
//    (no wrap), and o_err_seen <= 1.
//  - i_clr at edge: o_err_cnt <= 0, o_err_seen <= 0. If a push of an erroneous entry occurs
//    in the same cycle, i_clr wins and the entry is not counted. FIFO contents are unaffected.
//  - Status is stored verbatim. Entries with status != 0 are still buffered and delivered;
//    result bits of such entries are passed through as-is. X on the upstream result when
//    status != 0 is permitted.
//  - No combinational path from i_valid to o_ready or from i_ready to o_valid.
// TESTING
//  1. Reset then idle: all outputs 0, o_ready=1. Assert i_rsn low mid-burst with 3 entries
//     stored -> o_count=0 and o_valid=0 immediately (async).
//  2. Single entry: push result=4'hA, status=0 at edge N, i_ready=0 -> after N o_valid=1,
//     o_result=4'hA, o_count=1. Set i_ready=1 -> empty after the next edge.
//  3. Fill: push 4'h1..4'h4 with i_ready=0 -> o_count=4, o_ready=0. A 5th i_valid is not
//     accepted. Drain -> outputs 1,2,3,4 in order.
//  4. Simultaneous push/pop: with count=2, push and pop every cycle for 10 cycles -> count
//     stays 2, pointers wrap, output order matches input order.
//  5. Errors: push 3 entries with status=3'b001 and 1 with 3'b000 -> o_err_cnt=3, o_err_seen=1.
//     Pulse i_clr together with a status=3'b001 push -> o_err_cnt=0, o_err_seen=0, entry still
//     buffered.
//  6. Saturation with CNT_W=2: push 5 entries with status=3'b001 -> o_err_cnt=3, no wrap to 0.

Source files
------------

// File: rtl/exe_result_buffer_w15.sv
// exe_result_buffer_w15: result/status FIFO behind exe_unit_w15
// with a saturating error counter and a sticky error flag.
module exe_result_buffer_w15 #(
    parameter int ARG_BYTES = 4,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rsn,
    input  logic                       i_valid,
    input  logic [ARG_BYTES-1:0]       i_result,
    input  logic [2:0]                 i_status,
    output logic                       o_ready,
    output logic                       o_valid,
    output logic [ARG_BYTES-1:0]       o_result,
    output logic [2:0]                 o_status,
    input  logic                       i_ready,
    input  logic                       i_clr,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [CNT_W-1:0]           o_err_cnt,
    output logic                       o_err_seen
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ARG_BYTES-1:0] r_res [DEPTH];
    logic [2:0]           r_sts [DEPTH];
    logic [PW-1:0]        r_rd_ptr;
    logic [PW-1:0]        r_wr_ptr;
    logic [CW-1:0]        r_count;
    logic [CNT_W-1:0]     r_err_cnt;
    logic                 r_err_seen;

    logic w_push;
    logic w_pop;
    logic w_err;

    // Handshake decode; ready/valid depend only on the registered count.
    always_comb begin
        o_ready = (r_count != CW'(DEPTH));
        o_valid = (r_count != '0);
        w_push  = i_valid & o_ready;
        w_pop   = o_valid & i_ready;
        w_err   = w_push & (i_status != 3'b000);
    end

    // Head entry, forced to zero while the buffer is empty.
    always_comb begin
        o_result = '0;
        o_status = '0;
        if (o_valid) begin
            o_result = r_res[r_rd_ptr];
            o_status = r_sts[r_rd_ptr];
        end
    end

    // Entry storage written at the tail on every accepted push.
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_res[i] <= '0;
                r_sts[i] <= '0;
            end
        end else if (w_push) begin
            r_res[r_wr_ptr] <= i_result;
            r_sts[r_wr_ptr] <= i_status;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    // Error tracking; clear takes priority over a same-cycle error push.
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            r_err_cnt  <= '0;
            r_err_seen <= 1'b0;
        end else if (i_clr) begin
            r_err_cnt  <= '0;
            r_err_seen <= 1'b0;
        end else if (w_err) begin
            r_err_seen <= 1'b1;
            if (r_err_cnt != '1)
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign o_count    = r_count;
    assign o_err_cnt  = r_err_cnt;
    assign o_err_seen = r_err_seen;

endmodule

// File: tb/tb_exe_result_buffer_w15.sv
// tb_exe_result_buffer_w15: randomized and directed checks against
// a queue-based reference model of the result buffer.
module tb_exe_result_buffer_w15;

    logic       i_clk = 1'b0;
    logic       i_rsn;
    logic       i_valid;
    logic [3:0] i_result;
    logic [2:0] i_status;
    logic       i_ready;
    logic       i_clr;

    logic       o_ready,  o_valid,  o_err_seen;
    logic [3:0] o_result;
    logic [2:0] o_status;
    logic [2:0] o_count;
    logic [7:0] o_err_cnt;

    logic       s_ready,  s_valid,  s_err_seen;
    logic [3:0] s_result;
    logic [2:0] s_status;
    logic [2:0] s_count;
    logic [1:0] s_err_cnt;

    int checks = 0;
    int errors = 0;

    logic [6:0] q[$];
    int m_err8;
    int m_err2;
    bit m_seen;

    always #5 i_clk = ~i_clk;

    exe_result_buffer_w15 #(.ARG_BYTES(4), .DEPTH(4), .CNT_W(8)) dut (
        .i_clk(i_clk), .i_rsn(i_rsn), .i_valid(i_valid),
        .i_result(i_result), .i_status(i_status), .o_ready(o_ready),
        .o_valid(o_valid), .o_result(o_result), .o_status(o_status),
        .i_ready(i_ready), .i_clr(i_clr), .o_count(o_count),
        .o_err_cnt(o_err_cnt), .o_err_seen(o_err_seen)
    );

    exe_result_buffer_w15 #(.ARG_BYTES(4), .DEPTH(4), .CNT_W(2)) dut2 (
        .i_clk(i_clk), .i_rsn(i_rsn), .i_valid(i_valid),
        .i_result(i_result), .i_status(i_status), .o_ready(s_ready),
        .o_valid(s_valid), .o_result(s_result), .o_status(s_status),
        .i_ready(i_ready), .i_clr(i_clr), .o_count(s_count),
        .o_err_cnt(s_err_cnt), .o_err_seen(s_err_seen)
    );

    task automatic model_reset();
        q.delete();
        m_err8 = 0;
        m_err2 = 0;
        m_seen = 0;
    endtask

    task automatic step(input logic v, input logic [3:0] r,
                        input logic [2:0] s, input logic rd,
                        input logic c);
        bit push, pop;
        i_valid  = v;
        i_result = r;
        i_status = s;
        i_ready  = rd;
        i_clr    = c;
        push = v && (q.size() != 4);
        pop  = rd && (q.size() != 0);
        @(posedge i_clk);
        if (pop)
            void'(q.pop_front());
        if (push)
            q.push_back({r, s});
        if (c) begin
            m_err8 = 0;
            m_err2 = 0;
            m_seen = 0;
        end else if (push && s != 3'b000) begin
            m_seen = 1;
            if (m_err8 < 255) m_err8++;
            if (m_err2 < 3) m_err2++;
        end
        #1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_clr   = 1'b0;
    endtask

    task automatic test_reset();
        i_rsn = 1'b0;
        i_valid = 1'b1; i_result = 4'hF; i_status = 3'b111;
        i_ready = 1'b0; i_clr = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_count !== 3'd0 || o_result !== 4'h0 ||
            o_status !== 3'd0 || o_err_cnt !== 8'd0 || o_err_seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_state valid=%b cnt=%0d res=%h sts=%0d err=%0d seen=%b req all 0",
                     o_valid, o_count, o_result, o_status, o_err_cnt, o_err_seen);
        end
        i_valid = 1'b0;
        i_rsn = 1'b1;
        model_reset();
        step(0, 0, 0, 0, 0);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_count !== 3'd0) begin
            errors++;
            $display("FAIL idle ready=%b valid=%b cnt=%0d req 1 0 0",
                     o_ready, o_valid, o_count);
        end
        for (int i = 0; i < 3; i++)
            step(1, 4'(i + 7), 3'b001, 0, 0);
        checks++;
        if (o_count !== 3'd3 || o_err_cnt !== 8'd3) begin
            errors++;
            $display("FAIL pre_reset cnt=%0d err=%0d req 3 3", o_count, o_err_cnt);
        end
        #2;
        i_rsn = 1'b0;
        #1;
        checks++;
        if (o_count !== 3'd0 || o_valid !== 1'b0 || o_err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_reset cnt=%0d valid=%b err=%0d req 0 0 0",
                     o_count, o_valid, o_err_cnt);
        end
        @(posedge i_clk);
        #1;
        i_rsn = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        step(1, 4'hA, 3'b000, 0, 0);
        checks++;
        if (o_valid !== 1'b1 || o_result !== 4'hA || o_count !== 3'd1 ||
            o_status !== 3'd0) begin
            errors++;
            $display("FAIL single_push valid=%b res=%h cnt=%0d sts=%0d req 1 a 1 0",
                     o_valid, o_result, o_count, o_status);
        end
        step(0, 0, 0, 1, 0);
        checks++;
        if (o_valid !== 1'b0 || o_count !== 3'd0 || o_result !== 4'h0) begin
            errors++;
            $display("FAIL single_pop valid=%b cnt=%0d res=%h req 0 0 0",
                     o_valid, o_count, o_result);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++)
            step(1, 4'(i), 3'b000, 0, 0);
        checks++;
        if (o_count !== 3'd4 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill cnt=%0d ready=%b req 4 0", o_count, o_ready);
        end
        step(1, 4'h5, 3'b000, 0, 0);
        checks++;
        if (o_count !== 3'd4 || o_result !== 4'h1) begin
            errors++;
            $display("FAIL full_reject cnt=%0d head=%h req 4 1", o_count, o_result);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (o_valid !== 1'b1 || o_result !== 4'(i)) begin
                errors++;
                $display("FAIL drain_order valid=%b res=%h req 1 %h",
                         o_valid, o_result, 4'(i));
            end
            step(0, 0, 0, 1, 0);
        end
        checks++;
        if (o_valid !== 1'b0 || o_count !== 3'd0) begin
            errors++;
            $display("FAIL drain_empty valid=%b cnt=%0d req 0 0", o_valid, o_count);
        end
    endtask

    task automatic test_back_to_back();
        step(1, 4'h3, 3'b000, 0, 0);
        step(1, 4'h9, 3'b000, 0, 0);
        for (int i = 0; i < 10; i++) begin
            logic [3:0] r;
            r = 4'($urandom);
            step(1, r, 3'b000, 1, 0);
            checks++;
            if (o_count !== 3'd2 || o_valid !== 1'b1 ||
                {o_result, o_status} !== q[0]) begin
                errors++;
                $display("FAIL push_pop cyc=%0d cnt=%0d head=%h/%0d req 2 %h/%0d",
                         i, o_count, o_result, o_status, q[0][6:3], q[0][2:0]);
            end
        end
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
    endtask

    task automatic test_errors();
        step(1, 4'h1, 3'b001, 0, 0);
        step(1, 4'h2, 3'b001, 0, 0);
        step(1, 4'h3, 3'b000, 0, 0);
        step(1, 4'h4, 3'b001, 0, 0);
        checks++;
        if (o_err_cnt !== 8'd3 || o_err_seen !== 1'b1) begin
            errors++;
            $display("FAIL err_count err=%0d seen=%b req 3 1", o_err_cnt, o_err_seen);
        end
        step(0, 0, 0, 1, 0);
        step(1, 4'hC, 3'b001, 0, 1);
        checks++;
        if (o_err_cnt !== 8'd0 || o_err_seen !== 1'b0 || o_count !== 3'd4) begin
            errors++;
            $display("FAIL clr_wins err=%0d seen=%b cnt=%0d req 0 0 4",
                     o_err_cnt, o_err_seen, o_count);
        end
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 1, 0);
    endtask

    task automatic test_saturation();
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 4'(i), 3'b001, 1, 0);
            checks++;
            if (s_err_cnt !== 2'(m_err2) || s_err_seen !== 1'b1) begin
                errors++;
                $display("FAIL sat_step i=%0d err=%0d seen=%b req %0d 1",
                         i, s_err_cnt, s_err_seen, m_err2);
            end
        end
        checks++;
        if (s_err_cnt !== 2'd3 || o_err_cnt !== 8'd5) begin
            errors++;
            $display("FAIL saturate err2=%0d err8=%0d req 3 5", s_err_cnt, o_err_cnt);
        end
        for (int i = 0; i < 2; i++)
            step(0, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic [6:0] exp_head;
            checks++;
            if (o_ready !== (q.size() != 4)) begin
                errors++;
                $display("FAIL rnd_ready cyc=%0d got=%b req=%b",
                         i, o_ready, q.size() != 4);
            end
            step($urandom_range(0, 3) != 0, 4'($urandom), 3'($urandom_range(0, 3)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            exp_head = (q.size() != 0) ? q[0] : 7'd0;
            checks++;
            if (o_count !== 3'(q.size()) || o_valid !== (q.size() != 0) ||
                {o_result, o_status} !== exp_head ||
                o_err_cnt !== 8'(m_err8) || o_err_seen !== m_seen ||
                s_err_cnt !== 2'(m_err2)) begin
                errors++;
                $display("FAIL rnd cyc=%0d cnt=%0d head=%h err=%0d/%0d seen=%b req cnt=%0d head=%h err=%0d/%0d seen=%b",
                         i, o_count, {o_result, o_status}, o_err_cnt, s_err_cnt,
                         o_err_seen, q.size(), exp_head, m_err8, m_err2, m_seen);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_errors();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
